// File: rtl/miss_msg_det_pkg.sv
// miss_msg_det_pkg: shared default widths and session-jump limit for the MoldUDP64 receive path
//   DEF_SEQ_NUM_W   sequence number width
//   DEF_SID_W       session ID width
//   DEF_ML_W        message count width
//   DEF_SID_GAP_MAX largest forward sid jump still treated as missed sessions
package miss_msg_det_pkg;
    localparam int DEF_SEQ_NUM_W = 64;
    localparam int DEF_SID_W = 80;
    localparam int DEF_ML_W = 16;
    localparam logic [63:0] DEF_SID_GAP_MAX = 64'h8000_0000_0000_0000;
endpackage

// File: rtl/miss_msg_det.sv
// miss_msg_det: flags missing message ranges and missing sessions in the cycle of the packet header
//   clk, nreset                 clock, asynchronous active-low reset
//   v_i, sid_i, seq_num_i,
//   msg_cnt_i, eos_i            packet header (one cycle per packet)
//   miss_seq_num_*_o            in-session gap: valid, session, first missing seq, count
//   miss_sid_*_o                skipped session(s): valid, first sid, first seq, sid count, new seq
module miss_msg_det import miss_msg_det_pkg::*; #(
    parameter int SEQ_NUM_W = DEF_SEQ_NUM_W,
    parameter int SID_W = DEF_SID_W,
    parameter int ML_W = DEF_ML_W,
    parameter logic [SID_W-1:0] SID_GAP_MAX = SID_W'(DEF_SID_GAP_MAX)
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 v_i,
    input  logic [SID_W-1:0]     sid_i,
    input  logic [SEQ_NUM_W-1:0] seq_num_i,
    input  logic [ML_W-1:0]      msg_cnt_i,
    input  logic                 eos_i,
    output logic                 miss_seq_num_v_o,
    output logic [SID_W-1:0]     miss_seq_num_sid_o,
    output logic [SEQ_NUM_W-1:0] miss_seq_num_start_o,
    output logic [SEQ_NUM_W-1:0] miss_seq_num_cnt_o,
    output logic                 miss_sid_v_o,
    output logic [SID_W-1:0]     miss_sid_start_o,
    output logic [SEQ_NUM_W-1:0] miss_sid_seq_num_start_o,
    output logic [SID_W-1:0]     miss_sid_cnt_o,
    output logic [SEQ_NUM_W-1:0] miss_sid_seq_num_end_o
);
    logic [SID_W-1:0] sid_q, sid_d, sid_diff;
    logic [SEQ_NUM_W-1:0] seq_q, seq_d, end_seq;
    logic same, ahead, seq_gap, sid_gap;

    assign sid_diff = sid_i - sid_q;
    assign end_seq = seq_num_i + SEQ_NUM_W'(msg_cnt_i);
    assign same = sid_i == sid_q;
    // Forward jumps beyond SID_GAP_MAX are treated as resynchronisation, not loss
    assign ahead = !same && sid_diff <= SID_GAP_MAX;
    assign seq_gap = v_i && same && seq_num_i > seq_q;
    assign sid_gap = v_i && ahead;

    assign miss_seq_num_v_o = seq_gap;
    assign miss_seq_num_sid_o = seq_gap ? sid_q : '0;
    assign miss_seq_num_start_o = seq_gap ? seq_q : '0;
    assign miss_seq_num_cnt_o = seq_gap ? seq_num_i - seq_q : '0;
    assign miss_sid_v_o = sid_gap;
    assign miss_sid_start_o = sid_gap ? sid_q : '0;
    assign miss_sid_seq_num_start_o = sid_gap ? seq_q : '0;
    assign miss_sid_cnt_o = sid_gap ? sid_diff : '0;
    assign miss_sid_seq_num_end_o = sid_gap ? seq_num_i : '0;

    // Old/duplicate packets in the same session never move seq_q backwards
    always_comb begin
        sid_d = !v_i ? sid_q : eos_i ? sid_i + SID_W'(1) : (!same || end_seq > seq_q) ? sid_i : sid_q;
        seq_d = !v_i ? seq_q : eos_i ? '0 : (!same || end_seq > seq_q) ? end_seq : seq_q;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sid_q <= '0;
            seq_q <= '0;
        end else begin
            sid_q <= sid_d;
            seq_q <= seq_d;
        end
    end
endmodule

// File: tb/tb_miss_msg_det.sv
// tb_miss_msg_det: directed self-checking bench for miss_msg_det
module tb_miss_msg_det;
    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        v_i = 1'b0;
    logic [79:0] sid_i = '0;
    logic [63:0] seq_num_i = '0;
    logic [15:0] msg_cnt_i = '0;
    logic        eos_i = 1'b0;
    logic        miss_seq_num_v_o;
    logic [79:0] miss_seq_num_sid_o;
    logic [63:0] miss_seq_num_start_o;
    logic [63:0] miss_seq_num_cnt_o;
    logic        miss_sid_v_o;
    logic [79:0] miss_sid_start_o;
    logic [63:0] miss_sid_seq_num_start_o;
    logic [79:0] miss_sid_cnt_o;
    logic [63:0] miss_sid_seq_num_end_o;
    int checks = 0;
    int failures = 0;

    localparam logic [79:0] SID_R = 80'h8000_0000_0000_0005;
    localparam logic [79:0] SID_A = 80'h1_0000_0000_0000_0005;
    localparam logic [79:0] GAP_MAX = 80'h8000_0000_0000_0000;

    miss_msg_det dut (
        .clk(clk),
        .nreset(nreset),
        .v_i(v_i),
        .sid_i(sid_i),
        .seq_num_i(seq_num_i),
        .msg_cnt_i(msg_cnt_i),
        .eos_i(eos_i),
        .miss_seq_num_v_o(miss_seq_num_v_o),
        .miss_seq_num_sid_o(miss_seq_num_sid_o),
        .miss_seq_num_start_o(miss_seq_num_start_o),
        .miss_seq_num_cnt_o(miss_seq_num_cnt_o),
        .miss_sid_v_o(miss_sid_v_o),
        .miss_sid_start_o(miss_sid_start_o),
        .miss_sid_seq_num_start_o(miss_sid_seq_num_start_o),
        .miss_sid_cnt_o(miss_sid_cnt_o),
        .miss_sid_seq_num_end_o(miss_sid_seq_num_end_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag,
                           input logic sv, input logic [79:0] ssid, input logic [63:0] sst, input logic [63:0] scnt,
                           input logic dv, input logic [79:0] dst, input logic [63:0] dss, input logic [79:0] dcnt,
                           input logic [63:0] dend);
        chk({tag, ".seq_v"}, 80'(miss_seq_num_v_o), 80'(sv));
        chk({tag, ".seq_sid"}, miss_seq_num_sid_o, ssid);
        chk({tag, ".seq_start"}, 80'(miss_seq_num_start_o), 80'(sst));
        chk({tag, ".seq_cnt"}, 80'(miss_seq_num_cnt_o), 80'(scnt));
        chk({tag, ".sid_v"}, 80'(miss_sid_v_o), 80'(dv));
        chk({tag, ".sid_start"}, miss_sid_start_o, dst);
        chk({tag, ".sid_seq_start"}, 80'(miss_sid_seq_num_start_o), 80'(dss));
        chk({tag, ".sid_cnt"}, miss_sid_cnt_o, dcnt);
        chk({tag, ".sid_seq_end"}, 80'(miss_sid_seq_num_end_o), 80'(dend));
    endtask

    // Drive a header at the falling edge and check outputs before the next rising edge
    task automatic pkt(input string tag, input logic [79:0] sid, input logic [63:0] seq, input logic [15:0] cnt,
                       input logic eos,
                       input logic sv, input logic [79:0] ssid, input logic [63:0] sst, input logic [63:0] scnt,
                       input logic dv, input logic [79:0] dst, input logic [63:0] dss, input logic [79:0] dcnt,
                       input logic [63:0] dend);
        @(negedge clk);
        v_i = 1'b1;
        sid_i = sid;
        seq_num_i = seq;
        msg_cnt_i = cnt;
        eos_i = eos;
        #1;
        chk_all(tag, sv, ssid, sst, scnt, dv, dst, dss, dcnt, dend);
    endtask

    initial begin
        #2;
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        nreset = 1'b1;
        pkt("first",   0,  0, 5, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0);
        pkt("gap7",    0, 12, 3, 0,  1, 0, 5, 7,  0, 0, 0, 0, 0);
        pkt("cont15",  0, 15, 2, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0);
        pkt("gap3",    0, 20, 4, 0,  1, 0, 17, 3, 0, 0, 0, 0, 0);
        pkt("cont24",  0, 24, 1, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0);
        pkt("gap5",    0, 30, 2, 0,  1, 0, 25, 5, 0, 0, 0, 0, 0);
        pkt("eos",     0, 32, 0, 1,  0, 0, 0, 0,  0, 0, 0, 0, 0);
        pkt("newsess", 1,  4, 3, 0,  1, 1, 0, 4,  0, 0, 0, 0, 0);
        pkt("ahead3",  4,  2, 8, 0,  0, 0, 0, 0,  1, 1, 7, 3, 2);
        pkt("dup",     4,  0, 1, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0);
        pkt("afterdup",4, 11, 1, 0,  1, 4, 10, 1, 0, 0, 0, 0, 0);
        pkt("overlap", 4, 10, 5, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0);
        pkt("hb_gap",  4, 16, 0, 0,  1, 4, 15, 1, 0, 0, 0, 0, 0);
        pkt("hb_next", 4, 17, 0, 0,  1, 4, 16, 1, 0, 0, 0, 0, 0);
        pkt("resync",  SID_R, 100, 2, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0);
        pkt("post_rs", SID_R, 105, 1, 0,  1, SID_R, 102, 3,  0, 0, 0, 0, 0);
        pkt("gapmax",  SID_A, 0, 1, 0,  0, 0, 0, 0,  1, SID_R, 106, GAP_MAX, 0);
        pkt("backward", 3, 50, 1, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0);
        pkt("post_bw",  3, 51, 1, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0);
        @(negedge clk);
        v_i = 1'b0;
        sid_i = 80'd9;
        seq_num_i = 64'd99;
        #1;
        chk_all("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        v_i = 1'b1;
        sid_i = 80'd3;
        seq_num_i = 64'd60;
        msg_cnt_i = 16'd0;
        #1;
        chk_all("pre_rst", 1, 3, 52, 8, 0, 0, 0, 0, 0);
        nreset = 1'b0;
        #1;
        chk_all("mid_rst", 0, 0, 0, 0, 1, 0, 0, 3, 60);
        @(negedge clk);
        v_i = 1'b0;
        nreset = 1'b1;
        pkt("post_rst", 0, 2, 1, 0,  1, 0, 0, 2,  0, 0, 0, 0, 0);
        @(negedge clk);
        v_i = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
